// File: rtl/ccgc_phase_unwrap.sv
// Absolute-phase unwrapper: aligns fringe-order and wrapped-phase streams through
// elastic FIFOs, selects k by CCGC or plain gray rule, and emits phi + 2*pi*k.
`timescale 1ns/1ps
module ccgc_phase_unwrap #(
    parameter int K_WIDTH     = 4,
    parameter int PHASE_WIDTH = 32,
    parameter int FRAC_BITS   = 16,
    parameter int ABS_WIDTH   = 32,
    parameter int TWO_PI      = 411775,
    parameter int FIFO_DEPTH  = 16,
    parameter int LINE_PIXELS = 1280
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   frame_start,
    input  logic [K_WIDTH-2:0]     k1,
    input  logic [K_WIDTH-1:0]     k2,
    input  logic                   k_valid,
    output logic                   k_ready,
    input  logic [PHASE_WIDTH-1:0] wrapped_phase,
    input  logic                   wp_valid,
    output logic                   wp_ready,
    output logic [ABS_WIDTH-1:0]   abphase_out,
    output logic                   abphase_valid,
    input  logic                   abphase_ready,
    output logic                   abphase_last,
    output logic [1:0]             overflow
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int KWW = 2 * K_WIDTH - 1;
    localparam int KS  = K_WIDTH + 1;
    localparam int CW  = $clog2(LINE_PIXELS + 1);

    localparam logic signed [PHASE_WIDTH-1:0] HALF_PI_POS = PHASE_WIDTH'(TWO_PI / 4);
    localparam logic signed [PHASE_WIDTH-1:0] HALF_PI_NEG = PHASE_WIDTH'(-(TWO_PI / 4));
    localparam logic signed [ABS_WIDTH-1:0]   TWO_PI_A    = ABS_WIDTH'(TWO_PI);
    localparam logic signed [KS-1:0]          K_ONE       = KS'(1);
    localparam logic [LW-1:0]                 LVL_FULL    = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0]                 CNT_LAST    = CW'(LINE_PIXELS - 1);

    logic [KWW-1:0]         k_mem [FIFO_DEPTH];
    logic [PHASE_WIDTH-1:0] p_mem [FIFO_DEPTH];
    logic [AW-1:0]          k_wptr, k_rptr, p_wptr, p_rptr;
    logic [LW-1:0]          k_level, p_level;
    logic                   k_full, p_full, k_wr, p_wr, pop, advance;

    logic [KWW-1:0]                k_rd;
    logic [K_WIDTH-2:0]            k1_rd;
    logic [K_WIDTH-1:0]            k2_rd;
    logic signed [PHASE_WIDTH-1:0] phi_rd;
    logic signed [KS-1:0]          k_sel;

    logic                          s1_valid;
    logic signed [PHASE_WIDTH-1:0] s1_phi;
    logic signed [KS-1:0]          s1_k;
    logic signed [ABS_WIDTH-1:0]   phi_ext, k_ext, abs_calc;
    logic [CW-1:0]                 pix_cnt;
    logic                          flush;

    assign flush    = rst || frame_start;
    assign k_full   = (k_level == LVL_FULL);
    assign p_full   = (p_level == LVL_FULL);
    assign k_ready  = !k_full;
    assign wp_ready = !p_full;
    assign k_wr     = k_valid && !k_full && !frame_start;
    assign p_wr     = wp_valid && !p_full && !frame_start;
    assign advance  = !abphase_valid || abphase_ready;
    // Both streams leave together so k and phi words stay paired.
    assign pop      = (k_level != '0) && (p_level != '0) && advance;

    always_ff @(posedge clk) begin
        if (k_wr) k_mem[k_wptr] <= {k1, k2};
        if (p_wr) p_mem[p_wptr] <= wrapped_phase;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            k_wptr  <= '0;
            k_rptr  <= '0;
            p_wptr  <= '0;
            p_rptr  <= '0;
            k_level <= '0;
            p_level <= '0;
        end else begin
            if (k_wr) k_wptr <= k_wptr + AW'(1);
            if (p_wr) p_wptr <= p_wptr + AW'(1);
            if (pop) begin
                k_rptr <= k_rptr + AW'(1);
                p_rptr <= p_rptr + AW'(1);
            end
            case ({k_wr, pop})
                2'b10:   k_level <= k_level + LW'(1);
                2'b01:   k_level <= k_level - LW'(1);
                default: k_level <= k_level;
            endcase
            case ({p_wr, pop})
                2'b10:   p_level <= p_level + LW'(1);
                2'b01:   p_level <= p_level - LW'(1);
                default: p_level <= p_level;
            endcase
        end
    end

    // Sticky drop flags survive frame_start; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 2'b00;
        end else if (!frame_start) begin
            if (k_valid && k_full)  overflow[0] <= 1'b1;
            if (wp_valid && p_full) overflow[1] <= 1'b1;
        end
    end

    assign k_rd   = k_mem[k_rptr];
    assign k1_rd  = k_rd[KWW-1:K_WIDTH];
    assign k2_rd  = k_rd[K_WIDTH-1:0];
    assign phi_rd = p_mem[p_rptr];

    // Near the wrap edges the gray order k1 is unreliable; use the complementary code.
    always_comb begin
        k_sel = $signed({2'b00, k1_rd});
        if (mode) begin
            if (phi_rd <= HALF_PI_NEG)
                k_sel = $signed({1'b0, k2_rd});
            else if (phi_rd >= HALF_PI_POS)
                k_sel = $signed({1'b0, k2_rd}) - K_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            s1_valid <= 1'b0;
            s1_phi   <= '0;
            s1_k     <= '0;
        end else if (advance) begin
            s1_valid <= pop;
            if (pop) begin
                s1_phi <= phi_rd;
                s1_k   <= k_sel;
            end
        end
    end

    assign phi_ext  = ABS_WIDTH'(s1_phi);
    assign k_ext    = ABS_WIDTH'(s1_k);
    assign abs_calc = phi_ext + k_ext * TWO_PI_A;

    always_ff @(posedge clk) begin
        if (flush) begin
            abphase_valid <= 1'b0;
            abphase_out   <= '0;
        end else if (advance) begin
            abphase_valid <= s1_valid;
            if (s1_valid) abphase_out <= abs_calc;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            pix_cnt <= '0;
        end else if (abphase_valid && abphase_ready) begin
            if (pix_cnt == CNT_LAST) pix_cnt <= '0;
            else                     pix_cnt <= pix_cnt + CW'(1);
        end
    end

    assign abphase_last = abphase_valid && (pix_cnt == CNT_LAST);

endmodule

// File: tb/tb_ccgc_phase_unwrap.sv
// Scoreboard bench for ccgc_phase_unwrap (LINE_PIXELS=4 so line marks are exercised).
`timescale 1ns/1ps
module tb_ccgc_phase_unwrap;

    logic               clk = 1'b0;
    logic               rst, mode, frame_start;
    logic [2:0]         k1;
    logic [3:0]         k2;
    logic               k_valid, k_ready;
    logic [31:0]        wrapped_phase;
    logic               wp_valid, wp_ready;
    logic [31:0]        abphase_out;
    logic               abphase_valid, abphase_ready, abphase_last;
    logic [1:0]         overflow;

    int n_chk  = 0;
    int n_fail = 0;
    int px     = 0;
    logic [32:0] sb [$];
    logic        hold_chk = 1'b0;
    logic [31:0] held;

    always #5 clk = ~clk;

    ccgc_phase_unwrap #(.LINE_PIXELS(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .frame_start(frame_start),
        .k1(k1), .k2(k2), .k_valid(k_valid), .k_ready(k_ready),
        .wrapped_phase(wrapped_phase), .wp_valid(wp_valid), .wp_ready(wp_ready),
        .abphase_out(abphase_out), .abphase_valid(abphase_valid),
        .abphase_ready(abphase_ready), .abphase_last(abphase_last),
        .overflow(overflow)
    );

    // Monitor: pops the scoreboard on every output handshake, checks hold under stall.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                n_chk++;
                if (abphase_out !== held) begin
                    n_fail++;
                    $display("FAIL hold: got %0d expected %0d", $signed(abphase_out), $signed(held));
                end
            end
            if (abphase_valid && abphase_ready) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got %0d expected no output", $signed(abphase_out));
                end else begin
                    e = sb.pop_front();
                    if (abphase_out !== e[31:0] || abphase_last !== e[32]) begin
                        n_fail++;
                        $display("FAIL out: got %0d last %0b expected %0d last %0b",
                                 $signed(abphase_out), abphase_last, $signed(e[31:0]), e[32]);
                    end
                end
            end
            hold_chk = abphase_valid && !abphase_ready;
            held     = abphase_out;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d);
        sb.push_back({(px % 4 == 3), 32'(d)});
        px++;
    endtask

    task automatic send(input logic kv, input logic [2:0] a, input logic [3:0] b,
                        input logic pv, input int ph);
        k_valid = kv; k1 = a; k2 = b;
        wp_valid = pv; wrapped_phase = 32'(ph);
        cyc();
        k_valid = 1'b0; wp_valid = 1'b0;
    endtask

    task automatic pair(input logic [2:0] a, input logic [3:0] b, input int ph, input int exp);
        push(exp);
        send(1'b1, a, b, 1'b1, ph);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            cyc();
            n++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        cyc();
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        px = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; mode = 1'b0; frame_start = 1'b0;
        k1 = '0; k2 = '0; k_valid = 1'b0; wrapped_phase = '0; wp_valid = 1'b0;
        abphase_ready = 1'b1;
        repeat (3) cyc();
        chk("rst_k_ready", k_ready, 1);
        chk("rst_wp_ready", wp_ready, 1);
        chk("rst_valid", abphase_valid, 0);
        chk("rst_out", abphase_out, 0);
        chk("rst_last", abphase_last, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        cyc();

        // CCGC selection and latency
        mode = 1'b1;
        pair(3'd3, 4'd4, 0, 1235325);
        n = 0;
        while (!abphase_valid && n < 10) begin cyc(); n++; end
        chk("latency", n, 2);
        pair(3'd1, 4'd4, -150000, 1497100);
        pair(3'd3, 4'd4, 150000, 1385325);
        pair(3'd2, 4'd5, -102943, 1955932);
        pair(3'd2, 4'd5, -102942, 720608);
        pair(3'd2, 4'd5, 102942, 926492);
        pair(3'd1, 4'd0, 102943, -308832);
        pair(3'd1, 4'd9, 102943, 3397143);
        drain();

        mode = 1'b0;
        pair(3'd3, 4'd9, 150000, 1385325);
        pair(3'd7, 4'd0, -5000, 2877425);
        drain();
        fstart();

        // ten pixels, line marks on 3 and 7
        for (int i = 0; i < 10; i++) pair(3'(i % 8), 4'd0, i * 1000 - 4000, (i % 8) * 411775 + i * 1000 - 4000);
        drain();
        fstart();
        for (int i = 0; i < 6; i++) pair(3'd1, 4'd0, i, 411775 + i);
        drain();
        fstart();
        for (int i = 0; i < 4; i++) pair(3'd2, 4'd0, -i, 823550 - i);
        drain();

        // stale k words must be discarded by frame_start
        for (int i = 0; i < 3; i++) send(1'b1, 3'd7, 4'd0, 1'b0, 0);
        fstart();
        chk("flush_valid", abphase_valid, 0);
        chk("flush_k_ready", k_ready, 1);
        pair(3'd1, 4'd0, 10, 411785);
        pair(3'd1, 4'd0, 20, 411795);
        drain();
        fstart();

        // skew: k first, phase 10 cycles later
        for (int i = 1; i <= 5; i++) send(1'b1, 3'(i), 4'd0, 1'b0, 0);
        repeat (10) cyc();
        chk("skew_no_output", abphase_valid, 0);
        for (int i = 1; i <= 5; i++) begin
            push(i * 411775 + i * 100);
            send(1'b0, 3'd0, 4'd0, 1'b1, i * 100);
        end
        drain();
        fstart();

        // backpressure: two words sit in the pipeline, sixteen in each FIFO
        abphase_ready = 1'b0;
        for (int i = 0; i < 17; i++) pair(3'(i % 8), 4'd0, -i * 500, (i % 8) * 411775 - i * 500);
        chk("bp_k_ready_17", k_ready, 1);
        pair(3'd1, 4'd0, -8500, 411775 - 8500);
        chk("bp_k_ready_18", k_ready, 0);
        chk("bp_wp_ready_18", wp_ready, 0);
        chk("bp_overflow_pre", overflow, 0);
        send(1'b1, 3'd6, 4'd0, 1'b0, 0);
        chk("bp_overflow_k", overflow, 1);
        repeat (3) cyc();
        abphase_ready = 1'b1;
        drain();
        chk("bp_ready_back", k_ready, 1);
        fstart();
        chk("overflow_sticky", overflow, 1);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_clears_overflow", overflow, 0);
        chk("rst_wp_ready_again", wp_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
